// File: rtl/drp_xadc_pkg.sv
// drp_xadc_pkg: shared address map, DRP FSM encoding and CFG reset value for the XADC DRP responder
package drp_xadc_pkg;
   localparam logic [6:0]  XADC_ADDR_X   = 7'h16;
   localparam logic [6:0]  XADC_ADDR_Y   = 7'h17;
   localparam logic [6:0]  XADC_ADDR_CFG = 7'h41;
   localparam logic [15:0] CFG_RST       = 16'h0001;
   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} drp_state_t;
endpackage

// File: rtl/xadc_conv_sequencer.sv
// xadc_conv_sequencer: X/Y conversion timer; every CONV_PERIOD enabled cycles it
// captures the current channel, pulses eoc_out, reports channel_out and toggles X<->Y.
// Ports: clk_1MHz/rst_n (async active-low), en (sequencer enable), eoc_out, channel_out,
// cap (capture strobe, same edge as eoc_out rises), cap_y (1 = capture into Y, 0 = X).
module xadc_conv_sequencer #(
   parameter int         CONV_PERIOD = 26,
   parameter logic [6:0] ADDR_X      = 7'h16,
   parameter logic [6:0] ADDR_Y      = 7'h17
) (
   input  logic       clk_1MHz,
   input  logic       rst_n,
   input  logic       en,
   output logic       eoc_out,
   output logic [6:0] channel_out,
   output logic       cap,
   output logic       cap_y
);
   localparam int W = $clog2(CONV_PERIOD);
   logic [W-1:0] cnt_q, cnt_d;
   logic         ch_y_q, ch_y_d, eoc_q, eoc_d, tc;
   logic [6:0]   chan_q, chan_d;
   always_comb begin
      tc     = en && (cnt_q == W'(CONV_PERIOD - 1));
      cnt_d  = !en ? cnt_q : tc ? '0 : cnt_q + 1'b1;
      ch_y_d = tc ? !ch_y_q : ch_y_q;
      eoc_d  = tc;
      chan_d = tc ? (ch_y_q ? ADDR_Y : ADDR_X) : chan_q;
   end
   always_ff @(posedge clk_1MHz or negedge rst_n)
      if (!rst_n) begin
         cnt_q  <= '0;
         ch_y_q <= 1'b0;
         eoc_q  <= 1'b0;
         chan_q <= 7'h00;
      end else begin
         cnt_q  <= cnt_d;
         ch_y_q <= ch_y_d;
         eoc_q  <= eoc_d;
         chan_q <= chan_d;
      end
   assign eoc_out     = eoc_q;
   assign channel_out = chan_q;
   assign cap         = tc;
   assign cap_y       = ch_y_q;
endmodule

// File: rtl/drp_xadc_responder.sv
// drp_xadc_responder: simulated XADC DRP responder with X/Y result registers and CFG register.
// Ports: clk_1MHz/rst_n (async active-low); DRP request daddr_in/den_in/dwe_in/di_in;
// DRP response do_out/drdy_out; sequencer eoc_out/channel_out; analog stand-ins
// sample_x_in/sample_y_in; err_out (sticky den_in-while-busy flag).
module drp_xadc_responder import drp_xadc_pkg::*; #(
   parameter int         READ_LATENCY = 4,
   parameter int         CONV_PERIOD  = 26,
   parameter logic [6:0] ADDR_X       = XADC_ADDR_X,
   parameter logic [6:0] ADDR_Y       = XADC_ADDR_Y,
   parameter logic [6:0] ADDR_CFG     = XADC_ADDR_CFG
) (
   input  logic        clk_1MHz,
   input  logic        rst_n,
   input  logic [6:0]  daddr_in,
   input  logic        den_in,
   input  logic        dwe_in,
   input  logic [15:0] di_in,
   output logic [15:0] do_out,
   output logic        drdy_out,
   output logic        eoc_out,
   output logic [6:0]  channel_out,
   input  logic [11:0] sample_x_in,
   input  logic [11:0] sample_y_in,
   output logic        err_out
);
   drp_state_t  state_q, state_d;
   logic [3:0]  lat_q, lat_d;
   logic [6:0]  addr_q, addr_d;
   logic        we_q, we_d, err_q, err_d, accept, cap, cap_y;
   logic [15:0] wdata_q, wdata_d, snap_q, snap_d, do_q, do_d;
   logic [15:0] x_q, x_d, y_q, y_d, cfg_q, cfg_d, rd_mux;
   xadc_conv_sequencer #(.CONV_PERIOD(CONV_PERIOD), .ADDR_X(ADDR_X), .ADDR_Y(ADDR_Y)) u_seq (
      .clk_1MHz   (clk_1MHz),
      .rst_n      (rst_n),
      .en         (cfg_q[0]),
      .eoc_out    (eoc_out),
      .channel_out(channel_out),
      .cap        (cap),
      .cap_y      (cap_y)
   );
   always_comb begin
      rd_mux  = (daddr_in == ADDR_X) ? x_q : (daddr_in == ADDR_Y) ? y_q :
                (daddr_in == ADDR_CFG) ? cfg_q : 16'h0000;
      accept  = den_in && (state_q != S_WAIT);
      state_d = state_q;
      lat_d   = lat_q;
      addr_d  = addr_q;
      we_d    = we_q;
      wdata_d = wdata_q;
      snap_d  = snap_q;
      if (accept) begin
         // the WAIT phase lasts READ_LATENCY-1 cycles, so latency 1 skips it
         state_d = (READ_LATENCY == 1) ? S_RESP : S_WAIT;
         lat_d   = 4'(READ_LATENCY - 2);
         addr_d  = daddr_in;
         we_d    = dwe_in;
         wdata_d = di_in;
         snap_d  = dwe_in ? 16'h0000 : rd_mux;
      end else if (state_q == S_RESP)
         state_d = S_IDLE;
      else if (state_q == S_WAIT) begin
         if (lat_q == 4'd0)
            state_d = S_RESP;
         else
            lat_d = lat_q - 4'd1;
      end
      // do_out is reloaded only when entering RESP and held otherwise
      do_d  = (state_d == S_RESP) ? snap_d : do_q;
      err_d = err_q || (den_in && state_q == S_WAIT);
      cfg_d = (state_q == S_RESP && we_q && addr_q == ADDR_CFG) ? wdata_q : cfg_q;
      x_d   = (cap && !cap_y) ? {sample_x_in, 4'h0} : x_q;
      y_d   = (cap && cap_y) ? {sample_y_in, 4'h0} : y_q;
   end
   always_ff @(posedge clk_1MHz or negedge rst_n)
      if (!rst_n) begin
         state_q <= S_IDLE;
         lat_q   <= 4'd0;
         addr_q  <= 7'h00;
         we_q    <= 1'b0;
         wdata_q <= 16'h0000;
         snap_q  <= 16'h0000;
         do_q    <= 16'h0000;
         err_q   <= 1'b0;
         cfg_q   <= CFG_RST;
         x_q     <= 16'h0000;
         y_q     <= 16'h0000;
      end else begin
         state_q <= state_d;
         lat_q   <= lat_d;
         addr_q  <= addr_d;
         we_q    <= we_d;
         wdata_q <= wdata_d;
         snap_q  <= snap_d;
         do_q    <= do_d;
         err_q   <= err_d;
         cfg_q   <= cfg_d;
         x_q     <= x_d;
         y_q     <= y_d;
      end
   assign do_out   = do_q;
   assign drdy_out = (state_q == S_RESP);
   assign err_out  = err_q;
endmodule

// File: tb/tb_drp_xadc_responder.sv
// tb_drp_xadc_responder: scoreboard bench; stimulus queues expected DRP responses, a monitor checks them
module tb_drp_xadc_responder;
   localparam int L = 4;
   localparam int P = 26;
   typedef struct {
      logic [15:0] data;
      int          cyc;
   } exp_t;
   logic        clk = 1'b0, rst_n = 1'b0, den = 1'b0, dwe = 1'b0;
   logic [6:0]  daddr = 7'h00;
   logic [15:0] di = 16'h0000;
   logic [11:0] sx = 12'h123, sy = 12'h456;
   logic [15:0] do_out;
   logic        drdy_out, eoc_out, err_out, prev_drdy = 1'b0;
   logic [6:0]  channel_out, ch0, ch1;
   int          cyc = 0, checks = 0, fails = 0, eoc_cnt = 0, drdy_cnt = 0, dc;
   exp_t        sb[$];
   exp_t        e;
   logic [6:0]  chq[$];

   drp_xadc_responder #(.READ_LATENCY(L), .CONV_PERIOD(P)) dut (
      .clk_1MHz   (clk),
      .rst_n      (rst_n),
      .daddr_in   (daddr),
      .den_in     (den),
      .dwe_in     (dwe),
      .di_in      (di),
      .do_out     (do_out),
      .drdy_out   (drdy_out),
      .eoc_out    (eoc_out),
      .channel_out(channel_out),
      .sample_x_in(sx),
      .sample_y_in(sy),
      .err_out    (err_out)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         if (drdy_out) begin
            drdy_cnt++;
            if (prev_drdy) check("drdy_one_cycle", 32'(prev_drdy), 32'(0));
            if (sb.size() == 0) begin
               checks++;
               fails++;
               $display("FAIL stray_drdy: got drdy=1 at cycle %0d expected no response", cyc);
            end else begin
               e = sb.pop_front();
               check("drp_data", 32'(do_out), 32'(e.data));
               check("drp_latency", cyc, e.cyc);
            end
         end
         if (eoc_out) begin
            eoc_cnt++;
            chq.push_back(channel_out);
         end
      end
      prev_drdy = drdy_out;
   end

   task automatic wait_drain(input string name);
      for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
      if (sb.size() > 0) begin
         checks++;
         fails++;
         $display("FAIL %s_timeout: got %0d pending expected 0", name, sb.size());
         sb.delete();
      end
   endtask

   task automatic drp(input string name, input logic [6:0] a, input logic w, input logic [15:0] d,
                      input logic [15:0] exp);
      @(posedge clk);
      #1 daddr = a; dwe = w; di = d; den = 1'b1;
      sb.push_back('{exp, cyc + L});
      @(posedge clk);
      #1 den = 1'b0; dwe = 1'b0;
      wait_drain(name);
      repeat (3) @(posedge clk);
      #1 check({name, "_hold"}, 32'(do_out), 32'(exp));
   endtask

   initial begin
      #1;
      check("rst_do", 32'(do_out), 32'(0));
      check("rst_drdy", 32'(drdy_out), 32'(0));
      check("rst_eoc", 32'(eoc_out), 32'(0));
      check("rst_chan", 32'(channel_out), 32'(0));
      check("rst_err", 32'(err_out), 32'(0));
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (2 * P + 2) @(posedge clk);
      #1;
      ch0 = chq.size() > 0 ? chq[0] : 7'h7f;
      ch1 = chq.size() > 1 ? chq[1] : 7'h7f;
      check("eoc_count", eoc_cnt, 2);
      check("eoc_chan0", 32'(ch0), 32'h16);
      check("eoc_chan1", 32'(ch1), 32'h17);
      drp("rd_x", 7'h16, 1'b0, 16'h0, 16'h1230);
      drp("rd_y", 7'h17, 1'b0, 16'h0, 16'h4560);
      drp("rd_unmapped", 7'h00, 1'b0, 16'h0, 16'h0000);
      drp("wr_y", 7'h17, 1'b1, 16'hABCD, 16'h0000);
      drp("rd_y_after_wr", 7'h17, 1'b0, 16'h0, 16'h4560);
      drp("rd_cfg_rst", 7'h41, 1'b0, 16'h0, 16'h0001);
      drp("wr_cfg_off", 7'h41, 1'b1, 16'h0000, 16'h0000);
      eoc_cnt = 0;
      sx = 12'hABC;
      sy = 12'hDEF;
      repeat (3 * P) @(posedge clk);
      #1 check("frozen_eoc", eoc_cnt, 0);
      drp("rd_x_frozen", 7'h16, 1'b0, 16'h0, 16'h1230);
      drp("rd_y_frozen", 7'h17, 1'b0, 16'h0, 16'h4560);
      drp("wr_cfg_on", 7'h41, 1'b1, 16'h0003, 16'h0000);
      drp("rd_cfg", 7'h41, 1'b0, 16'h0, 16'h0003);
      repeat (2 * P + 4) @(posedge clk);
      drp("rd_x_new", 7'h16, 1'b0, 16'h0, 16'hABC0);
      drp("rd_y_new", 7'h17, 1'b0, 16'h0, 16'hDEF0);
      #1 check("err_before", 32'(err_out), 32'(0));
      @(posedge clk);
      #1 daddr = 7'h16; dwe = 1'b0; den = 1'b1;
      sb.push_back('{16'hABC0, cyc + L});
      @(posedge clk);
      #1 daddr = 7'h17;
      @(posedge clk);
      #1 den = 1'b0;
      wait_drain("err_txn");
      repeat (5) @(posedge clk);
      #1 check("err_set", 32'(err_out), 32'(1));
      check("err_do_hold", 32'(do_out), 32'hABC0);
      drp("rd_after_err", 7'h17, 1'b0, 16'h0, 16'hDEF0);
      #1 check("err_sticky", 32'(err_out), 32'(1));
      @(posedge clk);
      #1 daddr = 7'h17; dwe = 1'b0; den = 1'b1;
      sb.push_back('{16'hDEF0, cyc + L});
      @(posedge clk);
      #1 den = 1'b0;
      @(posedge clk);
      #2 rst_n = 1'b0;
      sb.delete();
      #1;
      check("mid_rst_drdy", 32'(drdy_out), 32'(0));
      check("mid_rst_do", 32'(do_out), 32'(0));
      check("mid_rst_err", 32'(err_out), 32'(0));
      check("mid_rst_eoc", 32'(eoc_out), 32'(0));
      check("mid_rst_chan", 32'(channel_out), 32'(0));
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      dc = drdy_cnt;
      repeat (10) @(posedge clk);
      #1 check("no_stray_drdy", drdy_cnt, dc);
      drp("rd_x_after_rst", 7'h16, 1'b0, 16'h0, 16'h0000);
      drp("rd_cfg_after_rst", 7'h41, 1'b0, 16'h0, 16'h0001);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule

// File: doc/drp_xadc_responder.md
# drp_xadc_responder

Responder end of the XADC Dynamic Reconfiguration Port (DRP) read handshake used by the joystick path. It answers `den_in`/`daddr_in` requests with `do_out`/`drdy_out` after a fixed latency and runs an X/Y conversion sequencer that emits `eoc_out`/`channel_out`. Result registers are loaded from bench- or logic-supplied 12-bit samples. It replaces the hard XADC for simulation and for bring-up on boards without analog joystick wiring.

## Interface
- `READ_LATENCY`, default 4: cycles from accepted `den_in` to the `drdy_out` pulse; legal range 1..15.
- `CONV_PERIOD`, default 26: cycles per conversion; legal minimum 4.
- `ADDR_X`, default 7'h16: X result register address (VAUX6).
- `ADDR_Y`, default 7'h17: Y result register address (VAUX7).
- `ADDR_CFG`, default 7'h41: configuration register address.
- `clk_1MHz`  in  1: the block clock; the whole block is synchronous to it.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `daddr_in`  in  7: DRP address.
- `den_in`  in  1: DRP enable, one-cycle request strobe.
- `dwe_in`  in  1: DRP write enable, qualified by `den_in`.
- `di_in`  in  16: DRP write data.
- `do_out`  out  16: DRP read data; valid while `drdy_out` is high, then held.
- `drdy_out`  out  1: one-cycle response strobe.
- `eoc_out`  out  1: one-cycle end-of-conversion pulse.
- `channel_out`  out  7: address of the channel that was just converted.
- `sample_x_in`  in  12: X analog stand-in, sampled at end of conversion.
- `sample_y_in`  in  12: Y analog stand-in, sampled at end of conversion.
- `err_out`  out  1: sticky flag for a protocol violation.

## Operation
- Registers:
  - X result: holds `{sample_x_in, 4'b0}`.
  - Y result: holds `{sample_y_in, 4'b0}`.
  - CFG:
    - bit0 = sequencer enable.
    - bits[15:1] read back as written.
- Reset values:
  - Results are 0.
  - CFG = 16'h0001.
  - `do_out` = 0, `drdy_out` = 0, `eoc_out` = 0, `channel_out` = 7'h00, `err_out` = 0.
- DRP FSM states are IDLE, WAIT and RESP.
  - IDLE to WAIT when `den_in` is high. On entry, latch `daddr_in`, `dwe_in` and `di_in`, and load the latency counter.
  - WAIT to RESP when the counter expires.
  - In RESP, `drdy_out` = 1.
    - On a read, `do_out` = the addressed register snapshot taken at the accept edge.
    - On a write, `do_out` = 0 and the register is updated at the RESP edge.
  - RESP to WAIT if `den_in` is high in the RESP cycle (back-to-back request accepted); otherwise RESP to IDLE.
- Address decode:
  - Reads of unmapped addresses return 16'h0000.
  - Writes to the X and Y result registers or to unmapped addresses are dropped but still acknowledged.
- Protocol violation: `den_in` high in the WAIT state is ignored and sets `err_out`, which stays high until reset.
- Conversion sequencer:
  - While CFG bit0 = 1, the period counter counts 0..CONV_PERIOD-1.
  - At terminal count:
    - Capture the current channel's sample into its result register.
    - Pulse `eoc_out`.
    - Set `channel_out` to that channel.
    - Toggle the channel. The order is X, Y, X, ... starting with X after reset.
  - Clearing bit0 freezes the counter and the channel; setting it again resumes from the frozen count.
- Result capture vs. DRP read of the same register in the same cycle: the read returns the old value. Snapshot-at-accept semantics apply.

## Timing
- `den_in` is sampled at edge T. `drdy_out` is high in the cycle after edge T+READ_LATENCY-1, i.e. `drdy_out` goes high READ_LATENCY cycles after `den_in`.
- Throughput: the maximum is one transaction per READ_LATENCY cycles when requests are issued back-to-back from RESP.
- `eoc_out` and `channel_out` change on the same edge as the result register update. A read accepted one cycle later returns the new value.
- CFG write effect on the sequencer: takes effect on the edge after the RESP cycle.
- Asynchronous reset asserted mid-transaction:
  - The transaction is aborted.
  - No `drdy_out` pulse is issued after release.
  - The FSM state returns to IDLE.

## Structure
- Package `drp_xadc_pkg`:
  - Address constants 7'h16, 7'h17 and 7'h41.
  - DRP FSM state encoding: IDLE, WAIT, RESP.
  - CFG reset value.
- Sub-module `xadc_conv_sequencer`:
  - Period counter and channel toggle.
  - Drives `eoc_out` and `channel_out`, and issues the capture strobe.
- Top level holds:
  - the DRP FSM;
  - the register file;
  - the error flag.

## Test plan
- Reset with samples X = 12'h123, Y = 12'h456, then run 2×CONV_PERIOD cycles:
  - `eoc_out` pulses exactly twice, with `channel_out` = 7'h16 then 7'h17.
  - Reading 7'h16 then 7'h17 returns 16'h1230 then 16'h4560.
- Read 7'h16 with READ_LATENCY = 4:
  - `drdy_out` is high exactly 4 cycles after `den_in`, for one cycle.
  - `do_out` stays stable afterwards.
- Write 16'h0000 to 7'h41, then change the samples and wait 3×CONV_PERIOD cycles:
  - No `eoc_out` pulse occurs.
  - The result registers are unchanged.
- Write 16'hABCD to 7'h17 and read it back:
  - The read returns the sampled Y value, not 16'hABCD.
- Reading unmapped address 7'h00 returns 16'h0000.
- Assert `den_in` during the WAIT state:
  - `err_out` goes to 1 and stays there.
  - The original transaction still completes.
- Assert `rst_n` low during WAIT:
  - All outputs return to their reset values.
  - No stray `drdy_out` pulse appears after release.
